nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nsa_rca4.sv | 36 +++
 rtl/nibble_serial_adder.sv | 173 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
//   Shared types and constants for the nibble-serial adder.
//   - nsa_state_e : controller states (IDLE, ADD, DONE)
//   - NIBBLE_W    : width of one serial adder step (one nibble)
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

endpackage : nibble_serial_adder_pkg

// File: rtl/nsa_rca4.sv
// -----------------------------------------------------------------------------
// nsa_rca4
//   Purely combinational 4-bit ripple-carry adder built from full-adder bit
//   slices. It is the datapath of one nibble step of the serial adder.
//   Ports:
//     a, b  : 4-bit addends
//     ci    : carry into bit 0
//     s     : 4-bit sum
//     co    : carry out of bit 3
//     c3    : carry into bit 3 (XOR with co gives signed overflow)
// -----------------------------------------------------------------------------
module nsa_rca4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] carryChain;

    assign carryChain[0] = ci;

    // One full-adder slice per bit; the carry ripples from bit 0 upward.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]            = a[i] ^ b[i] ^ carryChain[i];
        assign carryChain[i+1] = (a[i] & b[i]) | (carryChain[i] & (a[i] ^ b[i]));
    end

    assign co = carryChain[NIBBLE_W];
    assign c3 = carryChain[NIBBLE_W-1];

endmodule : nsa_rca4

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Adds (or optionally subtracts) two WIDTH-bit operands one nibble per clock
//   through a single 4-bit ripple adder. A result appears WIDTH/4 edges after
//   the operands are accepted and is held until the consumer takes it.
//
//   Parameter:
//     WIDTH     : operand/result width, a multiple of 4 and at least 8
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : synchronous active-low reset
//     in_valid  : operand pair offered
//     in_ready  : idle and able to accept (IDLE state)
//     a, b      : operands
//     cin       : carry-in (add only)
//     sub       : 1 = A-B (only honoured when subtraction is built in)
//     out_valid : result available (DONE state)
//     out_ready : consumer accepts result
//     sum       : result
//     cout      : carry out of MSB; for subtract 1 = no borrow
//     ovf       : two's-complement overflow
//
//   Build option:
//     NIBBLE_SERIAL_ADDER_SUB_EN : when defined, sub selects A-B by inverting B
//     and forcing the initial carry to 1. When undefined, sub is ignored and no
//     inversion logic exists.
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] sumReg_q, sumReg_d;
    logic             coutReg_q, coutReg_d;
    logic             ovfReg_q, ovfReg_d;

    logic [NIBBLE_W-1:0] nibA;
    logic [NIBBLE_W-1:0] nibB;
    logic [NIBBLE_W-1:0] nibSum;
    logic                nibCo;
    logic                nibC3;

    // The B operand and starting carry as they are latched at acceptance.
    // With subtraction built in, A-B becomes A + ~B + 1.
    logic [WIDTH-1:0] bLoad;
    logic             carryLoad;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign bLoad     = sub ? ~b : b;
    assign carryLoad = sub ? 1'b1 : cin;
`else
    logic unusedSub;
    assign unusedSub = sub;
    assign bLoad     = b;
    assign carryLoad = cin;
`endif

    // Select the nibble currently being processed from the latched operands.
    assign nibA = opA_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nibB = opB_q[idx_q*NIBBLE_W +: NIBBLE_W];

    nsa_rca4 u_rca4 (
        .a  (nibA),
        .b  (nibB),
        .ci (carry_q),
        .s  (nibSum),
        .co (nibCo),
        .c3 (nibC3)
    );

    // Next-state logic: accept operands in IDLE, step one nibble per edge in
    // ADD, and hold the result in DONE until the consumer takes it. Draining
    // only moves back to IDLE, so a new operation can start on the next edge
    // at the earliest.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        sumReg_d  = sumReg_q;
        coutReg_d = coutReg_q;
        ovfReg_d  = ovfReg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = bLoad;
                    carry_d = carryLoad;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sumReg_d[idx_q*NIBBLE_W +: NIBBLE_W] = nibSum;
                carry_d = nibCo;
                if (idx_q == LAST_IDX) begin
                    coutReg_d = nibCo;
                    ovfReg_d  = nibC3 ^ nibCo;
                    idx_d     = '0;
                    state_d   = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset. Reset clears the
    // result as well, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            sumReg_q  <= '0;
            coutReg_q <= 1'b0;
            ovfReg_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            sumReg_q  <= sumReg_d;
            coutReg_q <= coutReg_d;
            ovfReg_q  <= ovfReg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sumReg_q;
    assign cout      = coutReg_q;
    assign ovf       = ovfReg_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed, self-checking bench for nibble_serial_adder at WIDTH=16.
//   Expected results come from an arithmetic reference model and are queued
//   when operands are accepted, then popped when the result is presented.
//   Honours NIBBLE_SERIAL_ADDER_SUB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    result_t scoreboard[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain wide addition, with subtraction as A + ~B + 1.
    function automatic result_t model(input logic [WIDTH-1:0] opA,
                                      input logic [WIDTH-1:0] opB,
                                      input logic             carryIn,
                                      input logic             doSub);
        result_t          r;
        logic [WIDTH-1:0] bEff;
        logic             cEff;
        logic [WIDTH:0]   full;
        bEff = opB;
        cEff = carryIn;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        if (doSub) begin
            bEff = ~opB;
            cEff = 1'b1;
        end
`else
        if (doSub) begin
            bEff = opB;
        end
`endif
        full   = {1'b0, opA} + {1'b0, bEff} + {{WIDTH{1'b0}}, cEff};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (opA[WIDTH-1] == bEff[WIDTH-1]) && (r.sum[WIDTH-1] != opA[WIDTH-1]);
        return r;
    endfunction

    // One comparison: counts it, and reports any difference.
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one operand pair, wait for acceptance, queue the expected result
    // and then scramble the operand inputs. With holdValid, in_valid stays
    // high during the operation to show it is ignored outside IDLE.
    task automatic applyStimulus(input string tag,
                                 input logic [WIDTH-1:0] opA,
                                 input logic [WIDTH-1:0] opB,
                                 input logic             carryIn,
                                 input logic             doSub,
                                 input bit               holdValid);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        check({tag, " ready before offer"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = opA;
        b        = opB;
        cin      = carryIn;
        sub      = doSub;
        @(posedge clk); #1;
        scoreboard.push_back(model(opA, opB, carryIn, doSub));
        check({tag, " busy after accept"}, 32'(in_ready), 32'd0);
        in_valid = holdValid;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    // Wait (bounded) for the result, check latency and value, hold it under
    // backpressure for holdCycles, then drain and check the return to IDLE.
    task automatic checkOutput(input string tag, input int holdCycles);
        int      latency = 0;
        result_t exp;
        while (!out_valid && latency < 20) begin
            @(posedge clk); #1;
            latency++;
        end
        check({tag, " latency"}, 32'(latency), 32'd4);
        if (scoreboard.size() == 0) begin
            check({tag, " scoreboard entry"}, 32'd0, 32'd1);
            exp.sum  = '0;
            exp.cout = 1'b0;
            exp.ovf  = 1'b0;
        end else begin
            exp = scoreboard.pop_front();
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(exp.sum));
        check({tag, " cout"}, 32'(cout), 32'(exp.cout));
        check({tag, " ovf"}, 32'(ovf), 32'(exp.ovf));
        out_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " held sum"}, 32'(sum), 32'(exp.sum));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " drained in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " drained out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " retained sum"}, 32'(sum), 32'(exp.sum));
        check({tag, " retained cout"}, 32'(cout), 32'(exp.cout));
        in_valid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic add with backpressure");
        applyStimulus("add1234", 16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b0);
        checkOutput("add1234", 3);

        applyStimulus("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        checkOutput("addFFFF", 0);

        $display("[TB] in_valid held high during operation and drain");
        applyStimulus("add7FFF", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        checkOutput("add7FFF", 1);

        applyStimulus("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        checkOutput("sub5m7", 0);

        applyStimulus("add8000cin", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        checkOutput("add8000cin", 0);

        applyStimulus("sub8000m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        checkOutput("sub8000m1", 2);

        $display("[TB] reset abort in the middle of an operation");
        applyStimulus("abort", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        if (scoreboard.size() > 0) begin
            void'(scoreboard.pop_back());
        end
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);

        applyStimulus("afterAbort", 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        checkOutput("afterAbort", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_serial_adder
